// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: width/exception codes and FSM states shared by the load/store unit
package mem_lsu_pkg;
    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;
    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response bundle between the pipeline and the load/store unit
interface mem_lsu_if #(parameter int ADDR_W = 32);
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_width;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_pc;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_exc;
    logic [31:0]       resp_pc;
    logic              stall;
    modport master (
        output flush, req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_exc, resp_pc, stall
    );
    modport slave (
        input  flush, req_valid, req_we, req_width, req_sign, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_exc, resp_pc, stall
    );
endinterface

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: byte-lane steering for stores and lane extraction/extension for loads
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  width,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rext
);
    // returns {byte enables, lane-replicated data}; reserved width falls through to word
    function automatic logic [35:0] st_lane(logic [1:0] o, logic [1:0] w, logic [31:0] d);
        return w == WIDTH_B ? {4'b0001 << o, {4{d[7:0]}}} :
               w == WIDTH_H ? {o[1] ? 4'b1100 : 4'b0011, {2{d[15:0]}}} :
                              {4'hf, d};
    endfunction

    function automatic logic [31:0] ld_ext(logic [1:0] o, logic [1:0] w, logic s, logic [31:0] r);
        logic [31:0] sh;
        logic [15:0] h;
        sh = r >> {o, 3'b000};
        h  = o[1] ? r[31:16] : r[15:0];
        return w == WIDTH_B ? {{24{s & sh[7]}}, sh[7:0]} :
               w == WIDTH_H ? {{16{s & h[15]}}, h} : r;
    endfunction

    assign {be, wlane} = st_lane(off, width, wdata);
    assign rext = ld_ext(off, width, sign, rword);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle handshaked data memory for the MEM stage with alignment/range exceptions
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LAT         = 2,
    parameter int ADDR_W      = 32
) (
    input logic       clk,
    input logic       reset,
    mem_lsu_if.slave  bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic          l_we, l_sign;
    logic [1:0]    l_width;
    logic [IW+1:0] l_addr;
    logic [31:0]   l_wdata;
    logic [31:0]   rdata, pc;
    logic [1:0]    exc_q, exc;
    logic          misal, accept, access;
    logic          cur_we, cur_sign;
    logic [1:0]    cur_width;
    logic [IW+1:0] cur_addr;
    logic [31:0]   cur_wdata, rword, wlane, rext;
    logic [3:0]    be;
    logic [31:0]   mem [DEPTH_WORDS];

    assign misal  = (bus.req_width == WIDTH_H && bus.req_addr[0]) ||
                    (bus.req_width[1] && bus.req_addr[1:0] != 2'b00);
    assign exc    = misal ? EXC_ALIGN : |bus.req_addr[ADDR_W-1:IW+2] ? EXC_RANGE : EXC_NONE;
    assign accept = state == IDLE && bus.req_valid && !bus.flush;
    // with LAT=0 the access happens on the accept edge, so fields come straight from the bus
    assign access = reset && ((accept && exc == EXC_NONE && LAT == 0) ||
                              (state == WAIT && cnt == '0 && !bus.flush));

    assign cur_we    = state == IDLE ? bus.req_we : l_we;
    assign cur_sign  = state == IDLE ? bus.req_sign : l_sign;
    assign cur_width = state == IDLE ? bus.req_width : l_width;
    assign cur_addr  = state == IDLE ? bus.req_addr[IW+1:0] : l_addr;
    assign cur_wdata = state == IDLE ? bus.req_wdata : l_wdata;
    assign rword     = mem[cur_addr[IW+1:2]];

    mem_lsu_lane u_lane (
        .off   (cur_addr[1:0]),
        .width (cur_width),
        .sign  (cur_sign),
        .wdata (cur_wdata),
        .rword (rword),
        .be    (be),
        .wlane (wlane),
        .rext  (rext)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    nstate = !accept ? IDLE : (exc != EXC_NONE || LAT == 0) ? RESP : WAIT;
            WAIT:    nstate = bus.flush ? IDLE : cnt == '0 ? RESP : WAIT;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            l_we    <= 1'b0;
            l_sign  <= 1'b0;
            l_width <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
            exc_q   <= EXC_NONE;
            pc      <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                l_we    <= bus.req_we;
                l_sign  <= bus.req_sign;
                l_width <= bus.req_width;
                l_addr  <= bus.req_addr[IW+1:0];
                l_wdata <= bus.req_wdata;
                pc      <= bus.req_pc;
                exc_q   <= exc;
                rdata   <= '0;
                cnt     <= CW'(LAT > 0 ? LAT - 1 : 0);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access && !cur_we)
                rdata <= rext;
        end
    end

    always_ff @(posedge clk) begin
        if (access && cur_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[cur_addr[IW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end

    assign bus.req_ready  = state == IDLE;
    assign bus.stall      = state != IDLE;
    assign bus.resp_valid = state == RESP && !bus.flush;
    assign bus.resp_rdata = rdata;
    assign bus.resp_exc   = exc_q;
    assign bus.resp_pc    = pc;
endmodule
